cache_fill_fsm: RTL and testbench
=================================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous reset, active-high.
REQ-003 SHALL have port: miss_detected  in  1  cache miss flag (IF_stall from the cache).
REQ-004 SHALL have port: miss_address  in  16  byte address that missed.
REQ-005 SHALL have port: mem_data  in  16  word returned by memory.
REQ-006 SHALL have port: mem_data_valid  in  1  mem_data is valid this cycle.
REQ-007 SHALL have port: fsm_busy  out  1  fill in progress; pipeline holds while high.
REQ-008 SHALL have port: mem_read_en  out  1  memory read request this cycle.
REQ-009 SHALL have port: memory_address  out  16  request address (word aligned).
REQ-010 SHALL have port: fill_addr  out  16  cache address for the current data/tag write.
REQ-011 SHALL have port: write_data_array  out  1  drives the cache write_data_en.
REQ-012 SHALL have port: write_tag_array  out  1  drives the cache write_tag_en.

Function
REQ-013 SHALL implement states IDLE, FILL, TAG; encoding is free.
REQ-014 IDLE: on miss_detected=1, SHALL latch miss_address and enter FILL next edge; otherwise stay in IDLE.
REQ-015 Block base SHALL be {latched_addr[15:4], 4'h0}: 8 words of 16 bits, byte offsets 0,2,...,14.
REQ-016 FILL: a 4-bit issue count (0..8) SHALL assert mem_read_en with memory_address = base + 2*word(issue_cnt) on each cycle while issue_cnt<8, then increment; mem_read_en=0 once issue_cnt=8.
REQ-017 FILL: each cycle with mem_data_valid=1 SHALL assert write_data_array, drive fill_addr = base + 2*word(recv_cnt), then increment the 4-bit receive count.
REQ-018 Request issue and response receipt SHALL proceed concurrently; memory latency is arbitrary (at least 1 cycle); in-order return is guaranteed by memory.
REQ-019 FILL->TAG SHALL occur on the edge at which the 8th valid word is received.
REQ-020 TAG: SHALL assert write_tag_array for exactly one cycle with fill_addr = latched_addr, then return to IDLE.
REQ-021 fsm_busy SHALL be 1 in FILL and TAG and 0 in IDLE; it is a registered-state decode with no combinational path from miss_detected.
REQ-022 miss_detected while FILL/TAG SHALL be ignored; no new latch occurs.
REQ-023 mem_data_valid in IDLE or TAG SHALL be ignored: no write, no count change.
REQ-024 Outside FILL, write_data_array=0 and mem_read_en=0; outside TAG, write_tag_array=0.
REQ-025 When no write is active, fill_addr SHALL equal latched_addr.
REQ-026 Address arithmetic SHALL be 16-bit; the offset field SHALL never carry into bits [15:4].
REQ-027 A miss pending in IDLE immediately after TAG SHALL start a new fill on the next edge (back-to-back misses).

Reset
REQ-028 rst=1 SHALL immediately force IDLE, clear both counters and the latched address, and drive fsm_busy, mem_read_en, write_data_array and write_tag_array to 0; memory_address and fill_addr go to 16'h0000.
REQ-029 rst mid-fill SHALL abandon the fill with no tag write; in-flight memory responses arriving after reset SHALL be ignored (IDLE rule).

Configuration
REQ-030 Macro FILL_CRITICAL_WORD_FIRST_EN defined: word(n) = (latched_addr[3:1] + n) mod 8, so the missing word is requested and written first, wrapping past offset 14 to offset 0.
REQ-031 Macro FILL_CRITICAL_WORD_FIRST_EN undefined: word(n) = n, so the fill is strictly offset 0 to 14; all other behaviour is identical.

Verification
REQ-032 Reset, then miss 16'h1234 and a 4-cycle memory -> mem_read_en high 8 cycles at 0x1230..0x123E; 8 write_data_array pulses; then one write_tag_array pulse with fill_addr 0x1234; fsm_busy falls next cycle (macro off).
REQ-033 Same miss with FILL_CRITICAL_WORD_FIRST_EN -> request/write order 0x1234,0x1236,...,0x123E,0x1230,0x1232.
REQ-034 Memory inserts valid gaps (pattern 1,0,0,1...) -> writes only on valid cycles, fill_addr advances only on writes, TAG after exactly 8 writes.
REQ-035 Assert rst after 3 words received, then 5 stray mem_data_valid pulses -> all outputs 0 at once; no data or tag writes; FSM stays IDLE.
REQ-036 miss_detected held high through the fill with address changed to 0x5432 mid-fill -> the fill still targets 0x1230 block; a new fill for 0x5430 starts the cycle after TAG.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache line fill controller: IDLE -> FILL (8 words) -> TAG.
// Optional macro FILL_CRITICAL_WORD_FIRST_EN starts the fill at the missing word and wraps.
module cache_fill_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic [15:0] mem_data,
    input  logic        mem_data_valid,
    output logic        fsm_busy,
    output logic        mem_read_en,
    output logic [15:0] memory_address,
    output logic [15:0] fill_addr,
    output logic        write_data_array,
    output logic        write_tag_array
);

    typedef enum logic [1:0] {IDLE, FILL, TAG} state_t;

    state_t      state, state_nxt;
    logic [15:0] latched_addr, latched_nxt;
    logic [3:0]  issue_cnt, issue_nxt;
    logic [3:0]  recv_cnt, recv_nxt;
    logic [2:0]  issue_word, recv_word;

    // Data is written to the cache array directly from memory; the controller never looks at it.
    logic unused_mem_data;
    assign unused_mem_data = ^mem_data;

`ifdef FILL_CRITICAL_WORD_FIRST_EN
    assign issue_word = latched_addr[3:1] + issue_cnt[2:0];
    assign recv_word  = latched_addr[3:1] + recv_cnt[2:0];
`else
    assign issue_word = issue_cnt[2:0];
    assign recv_word  = recv_cnt[2:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            latched_addr <= 16'h0000;
            issue_cnt    <= 4'd0;
            recv_cnt     <= 4'd0;
        end else begin
            state        <= state_nxt;
            latched_addr <= latched_nxt;
            issue_cnt    <= issue_nxt;
            recv_cnt     <= recv_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        latched_nxt = latched_addr;
        issue_nxt   = issue_cnt;
        recv_nxt    = recv_cnt;
        case (state)
            IDLE: begin
                if (miss_detected) begin
                    latched_nxt = miss_address;
                    issue_nxt   = 4'd0;
                    recv_nxt    = 4'd0;
                    state_nxt   = FILL;
                end
            end
            FILL: begin
                if (!issue_cnt[3]) begin
                    issue_nxt = issue_cnt + 4'd1;
                end
                if (mem_data_valid) begin
                    recv_nxt = recv_cnt + 4'd1;
                    if (recv_cnt == 4'd7) begin
                        state_nxt = TAG;
                    end
                end
            end
            TAG: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // All outputs decode registered state; only the data write strobe follows mem_data_valid.
    assign fsm_busy         = (state != IDLE);
    assign mem_read_en      = (state == FILL) && !issue_cnt[3];
    assign write_data_array = (state == FILL) && mem_data_valid;
    assign write_tag_array  = (state == TAG);

    // Offset is concatenated, not added, so it can never carry into the block index.
    assign memory_address = {latched_addr[15:4], issue_word, 1'b0};
    assign fill_addr      = write_data_array ? {latched_addr[15:4], recv_word, 1'b0}
                                             : latched_addr;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - scoreboard bench for cache_fill_fsm.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] mem_data;
    logic        mem_data_valid;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic [15:0] fill_addr;
    logic        write_data_array;
    logic        write_tag_array;

    cache_fill_fsm dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .mem_data         (mem_data),
        .mem_data_valid   (mem_data_valid),
        .fsm_busy         (fsm_busy),
        .mem_read_en      (mem_read_en),
        .memory_address   (memory_address),
        .fill_addr        (fill_addr),
        .write_data_array (write_data_array),
        .write_tag_array  (write_tag_array)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_req[$];
    logic [15:0] exp_wr[$];
    logic [15:0] exp_tag[$];
    int          pend[$];
    int          latency  = 4;
    bit          gap_mode = 1'b0;
    bit          stray    = 1'b0;
    int          cyc      = 0;
    int          wr_seen  = 0;
    bit          prev_tag = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: in-order, fixed minimum latency, optional 1,0,0 valid pattern.
    initial begin
        mem_data_valid = 1'b0;
        mem_data       = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) pend.delete();
            else if (mem_read_en) pend.push_back(cyc);
            mem_data_valid = 1'b0;
            if (stray) begin
                mem_data_valid = (cyc % 2 == 0);
            end else if (pend.size() > 0 && (cyc - pend[0]) >= latency
                         && (!gap_mode || (cyc % 3 == 0))) begin
                mem_data_valid = 1'b1;
                mem_data       = 16'hA000 ^ 16'(cyc);
                void'(pend.pop_front());
            end
        end
    end

    // Monitor: compares each presented request/write against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_read_en) begin
                if (exp_req.size() == 0) check("req_unexpected", memory_address, 16'hxxxx);
                else check("req_addr", memory_address, exp_req.pop_front());
            end
            if (write_data_array) begin
                wr_seen++;
                if (exp_wr.size() == 0) check("wr_unexpected", fill_addr, 16'hxxxx);
                else check("wr_addr", fill_addr, exp_wr.pop_front());
            end
            if (write_tag_array) begin
                if (exp_tag.size() == 0) check("tag_unexpected", fill_addr, 16'hxxxx);
                else check("tag_addr", fill_addr, exp_tag.pop_front());
                check("tag_busy", 16'(fsm_busy), 16'd1);
                check("tag_no_data", 16'(write_data_array), 16'd0);
            end
            if (prev_tag) check("busy_fall", 16'(fsm_busy), 16'd0);
            prev_tag = write_tag_array;
        end
    end

    task automatic push_fill(input logic [15:0] a);
        logic [2:0] w;
        for (int n = 0; n < 8; n++) begin
`ifdef FILL_CRITICAL_WORD_FIRST_EN
            w = a[3:1] + 3'(n);
`else
            w = 3'(n);
`endif
            exp_req.push_back({a[15:4], w, 1'b0});
            exp_wr.push_back({a[15:4], w, 1'b0});
        end
        exp_tag.push_back(a);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300 && fsm_busy; i++) begin
            @(posedge clk);
            #1;
        end
        check(name, 16'(fsm_busy), 16'd0);
    endtask

    task automatic check_drained(input string name);
        check(name, 16'(exp_req.size() + exp_wr.size() + exp_tag.size()), 16'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  16'(fsm_busy),         16'd0);
        check({tag, "_rd"},    16'(mem_read_en),      16'd0);
        check({tag, "_wd"},    16'(write_data_array), 16'd0);
        check({tag, "_wt"},    16'(write_tag_array),  16'd0);
        check({tag, "_maddr"}, memory_address,        16'h0000);
        check({tag, "_faddr"}, fill_addr,             16'h0000);
    endtask

    task automatic start_miss(input logic [15:0] a);
        miss_detected = 1'b1;
        miss_address  = a;
        @(posedge clk);
        #1;
        check("busy_on", 16'(fsm_busy), 16'd1);
        miss_detected = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        miss_detected = 1'b0;
        miss_address  = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Plain fill, 4-cycle memory.
        latency = 4;
        push_fill(16'h1234);
        start_miss(16'h1234);
        wait_idle("fill_a_done");
        check_drained("fill_a_drained");

        // Valid gaps, offset 14 miss exercises the wrap.
        latency  = 1;
        gap_mode = 1'b1;
        push_fill(16'hABCE);
        start_miss(16'hABCE);
        wait_idle("fill_b_done");
        check_drained("fill_b_drained");
        gap_mode = 1'b0;

        // Miss held through the fill with a changing address, then back-to-back.
        latency = 3;
        push_fill(16'h1234);
        push_fill(16'h5432);
        miss_detected = 1'b1;
        miss_address  = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        miss_address = 16'h5432;
        wait_idle("fill_c1_done");
        @(posedge clk);
        #1;
        check("b2b_busy", 16'(fsm_busy), 16'd1);
        miss_detected = 1'b0;
        wait_idle("fill_c2_done");
        check_drained("fill_c_drained");

        // Reset after three received words, then stray responses.
        latency = 2;
        wr_seen = 0;
        push_fill(16'h2468);
        start_miss(16'h2468);
        for (int i = 0; i < 100 && wr_seen < 3; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_req.delete();
        exp_wr.delete();
        exp_tag.delete();
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        stray = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        stray = 1'b0;
        check("stray_busy", 16'(fsm_busy), 16'd0);
        check("stray_writes", 16'(wr_seen), 16'd3);
        @(posedge clk);
        #1;

        // Recovery fill at the top of a block.
        latency = 1;
        push_fill(16'h0FFE);
        start_miss(16'h0FFE);
        wait_idle("fill_d_done");
        check_drained("fill_d_drained");
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
